// File: rtl/or1200_assert_event_logger_pkg.sv
// Shared constants for the assertion event logger: register map, entry layout, IRQ FSM states.
// Optional halt support is selected with OR1200_ASSERT_HALT_EN.
package or1200_assert_event_logger_pkg;

   localparam logic [1:0] ADDR_MASK      = 2'd0;
   localparam logic [1:0] ADDR_STATUS    = 2'd1;
   localparam logic [1:0] ADDR_HALT_MASK = 2'd2;
   localparam logic [1:0] ADDR_CTRL      = 2'd3;

   localparam int unsigned ENTRY_PC_LSB  = 0;
   localparam int unsigned ENTRY_VEC_LSB = 32;
   localparam int unsigned ENTRY_W       = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_HALT = 2'd2
   } irq_state_e;

endpackage

// File: rtl/or1200_assert_event_fifo.sv
// Generic synchronous FIFO with push/pop/full/empty/count; DEPTH must be a power of two.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module or1200_assert_event_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign empty     = (r_count == '0);
   assign full      = (r_count == CNT_FULL);
   assign count     = r_count;
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);
   assign dout      = empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
            r_wr_ptr        <= r_wr_ptr + PTR_ONE;
         end
         if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
         if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_ONE;
         else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_ONE;
      end
   end

endmodule

// File: rtl/or1200_assert_event_logger.sv
// Logs rising edges of the assertion checker vector into a FIFO with IRQ and config registers.
// Define OR1200_ASSERT_HALT_EN to add the HALT state and HALT_MASK register.
module or1200_assert_event_logger
   import or1200_assert_event_logger_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned DROP_W     = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [31:0]         checkers_fired,
   input  logic [31:0]         ex_pc,
   input  logic                irq_ack,
   input  logic                ev_rd,
   output logic                ev_valid,
   output logic [ENTRY_W-1:0]  ev_data,
   output logic                irq,
   output logic                halt_req,
   input  logic                cfg_we,
   input  logic [1:0]          cfg_addr,
   input  logic [31:0]         cfg_wdata,
   output logic [31:0]         cfg_rdata
);

   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned CTRL_W = DROP_W + 1 + CNT_W;
   localparam logic [DROP_W-1:0] DROP_ONE = 1;

   logic [31:0]        r_fired_prev;
   logic [31:0]        r_mask;
   logic [31:0]        r_status;
   logic               r_ovf;
   logic [DROP_W-1:0]  r_drop;
   irq_state_e         r_state;
   irq_state_e         w_state_nxt;
   logic [31:0]        w_new_fire;
   logic               w_push;
   logic               w_pop;
   logic               w_drop;
   logic               w_fifo_full;
   logic               w_fifo_empty;
   logic [CNT_W-1:0]   w_count;
   logic [CTRL_W-1:0]  w_ctrl;
   logic [ENTRY_W-1:0] w_entry;
   logic [31:0]        w_halt_mask;

   assign w_new_fire = enable ? (checkers_fired & ~r_fired_prev & r_mask) : '0;
   assign w_push     = |w_new_fire;
   assign w_pop      = ev_rd && ev_valid;
   assign w_drop     = w_push && w_fifo_full && !w_pop;
   assign ev_valid   = !w_fifo_empty;
   assign w_ctrl     = {r_drop, r_ovf, w_count};

   always_comb begin
      w_entry = '0;
      w_entry[ENTRY_VEC_LSB +: 32] = w_new_fire;
      w_entry[ENTRY_PC_LSB  +: 32] = ex_pc;
   end

   or1200_assert_event_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_entry),
      .dout  (ev_data),
      .full  (w_fifo_full),
      .empty (w_fifo_empty),
      .count (w_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fired_prev <= '0;
         r_mask       <= '1;
         r_status     <= '0;
         r_ovf        <= 1'b0;
         r_drop       <= '0;
      end else begin
         if (enable) r_fired_prev <= checkers_fired;
         if (cfg_we && cfg_addr == ADDR_MASK) r_mask <= cfg_wdata;
         // New events win over a same-cycle write-1-to-clear
         r_status <= (r_status & ~((cfg_we && cfg_addr == ADDR_STATUS) ? cfg_wdata : '0))
                     | w_new_fire;
         if (cfg_we && cfg_addr == ADDR_CTRL && cfg_wdata[0]) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
         end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop != '1) r_drop <= r_drop + DROP_ONE;
         end
      end
   end

`ifdef OR1200_ASSERT_HALT_EN
   logic [31:0] r_halt_mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                      r_halt_mask <= '0;
      else if (cfg_we && cfg_addr == ADDR_HALT_MASK) r_halt_mask <= cfg_wdata;
   end

   assign w_halt_mask = r_halt_mask;
   assign halt_req    = (r_state == ST_HALT);
   assign irq         = (r_state == ST_PEND) || (r_state == ST_HALT);
`else
   assign w_halt_mask = '0;
   assign halt_req    = 1'b0;
   assign irq         = (r_state == ST_PEND);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_push) w_state_nxt = ST_PEND;
         ST_PEND: if (irq_ack && !w_push) w_state_nxt = ST_IDLE;
         ST_HALT: if (irq_ack) w_state_nxt = w_push ? ST_PEND : ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
`ifdef OR1200_ASSERT_HALT_EN
      if ((w_new_fire & w_halt_mask) != '0) w_state_nxt = ST_HALT;
`endif
   end

   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         ADDR_MASK:      cfg_rdata = r_mask;
         ADDR_STATUS:    cfg_rdata = r_status;
         ADDR_HALT_MASK: cfg_rdata = w_halt_mask;
         ADDR_CTRL:      cfg_rdata = {{(32-CTRL_W){1'b0}}, w_ctrl};
         default:        cfg_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_or1200_assert_event_logger.sv
// Scoreboard bench for or1200_assert_event_logger: stimulus queues expected FIFO entries,
// a negedge monitor pops and compares them whenever the bench reads the FIFO.
module tb_or1200_assert_event_logger;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b1;
   logic [31:0] checkers_fired = '0;
   logic [31:0] ex_pc = '0;
   logic        irq_ack = 1'b0;
   logic        ev_rd = 1'b0;
   logic        ev_valid;
   logic [63:0] ev_data;
   logic        irq;
   logic        halt_req;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_addr = '0;
   logic [31:0] cfg_wdata = '0;
   logic [31:0] cfg_rdata;

   int unsigned errors = 0;
   int unsigned checks = 0;
   logic [63:0] exp_q [$];

   or1200_assert_event_logger #(.FIFO_DEPTH(8), .DROP_W(8)) dut (
      .clk(clk), .rst(rst), .enable(enable), .checkers_fired(checkers_fired),
      .ex_pc(ex_pc), .irq_ack(irq_ack), .ev_rd(ev_rd), .ev_valid(ev_valid),
      .ev_data(ev_data), .irq(irq), .halt_req(halt_req), .cfg_we(cfg_we),
      .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every accepted pop must match the oldest expected entry
   always @(negedge clk) begin
      if (!rst && ev_rd && ev_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ev_data: got %h expected no entry", ev_data);
         end else begin
            check("ev_data", ev_data, exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_entry(input logic [31:0] vec, input logic [31:0] pc);
      exp_q.push_back({vec, pc});
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
      cfg_addr = a;
      #1;
      check(name, {32'h0, cfg_rdata}, {32'h0, exp});
   endtask

   task automatic fire(input logic [31:0] vec, input logic [31:0] pc);
      checkers_fired = vec; ex_pc = pc;
      step();
   endtask

   task automatic drain(input int unsigned n);
      ev_rd = 1'b1;
      for (int unsigned i = 0; i < n; i++) step();
      ev_rd = 1'b0;
   endtask

   task automatic ack();
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
   endtask

   initial begin
      // 1. reset state
      step(); step();
      rst = 1'b0;
      step();
      rd_check("mask_reset", 2'd0, 32'hFFFF_FFFF);
      check("irq_reset", {63'h0, irq}, 64'h0);
      check("ev_valid_reset", {63'h0, ev_valid}, 64'h0);
      check("halt_reset", {63'h0, halt_req}, 64'h0);
      check("ev_data_reset", ev_data, 64'h0);

      // 2. single rising edge, then held
      fire(32'h4, 32'hA00);
      expect_entry(32'h4, 32'hA00);
      check("ev_valid_push", {63'h0, ev_valid}, 64'h1);
      check("irq_push", {63'h0, irq}, 64'h1);
      check("ev_data_head", ev_data, {32'h4, 32'hA00});
      rd_check("status_bit2", 2'd1, 32'h4);
      fire(32'h4, 32'hA04);
      fire(32'h4, 32'hA08);
      rd_check("ctrl_held", 2'd3, 32'h1);
      drain(1);
      fire(32'h0, 32'h0);
      check("ev_valid_empty", {63'h0, ev_valid}, 64'h0);
      ack();
      check("irq_acked", {63'h0, irq}, 64'h0);
      cfg_write(2'd1, 32'h4);
      rd_check("status_w1c", 2'd1, 32'h0);

      // enable=0 forms no event and does not load fired_prev
      enable = 1'b0;
      fire(32'h1, 32'hB00);
      check("no_event_disabled", {63'h0, ev_valid}, 64'h0);
      enable = 1'b1;
      fire(32'h1, 32'hB04);
      expect_entry(32'h1, 32'hB04);
      fire(32'h0, 32'h0);
      drain(1);
      ack();

      // 3. masking
      cfg_write(2'd0, 32'hFFFF_FFFB);
      fire(32'h4, 32'hC00);
      fire(32'h0, 32'hC04);
      check("masked_no_entry", {63'h0, ev_valid}, 64'h0);
      check("masked_no_irq", {63'h0, irq}, 64'h0);
      fire(32'hC, 32'hC08);
      expect_entry(32'h8, 32'hC08);
      check("masked_irq", {63'h0, irq}, 64'h1);
      fire(32'h0, 32'h0);
      rd_check("masked_count", 2'd3, 32'h1);
      drain(1);
      ack();
      cfg_write(2'd0, 32'hFFFF_FFFF);

      // 4. overflow: 11 events into 8 entries
      for (int unsigned i = 0; i < 11; i++) begin
         fire(32'h1 << i, 32'h100 + i);
         if (i < 8) expect_entry(32'h1 << i, 32'h100 + i);
      end
      fire(32'h0, 32'h0);
      rd_check("ctrl_overflow", 2'd3, 32'h78);
      ev_rd = 1'b1;
      fire(32'h0010_0000, 32'h200);
      expect_entry(32'h0010_0000, 32'h200);
      ev_rd = 1'b0;
      fire(32'h0, 32'h0);
      rd_check("ctrl_push_pop_full", 2'd3, 32'h78);
      rd_check("status_incl_dropped", 2'd1, 32'h0010_07FF);
      cfg_write(2'd3, 32'h1);
      rd_check("ctrl_cleared", 2'd3, 32'h8);
      drain(8);
      check("ev_valid_drained", {63'h0, ev_valid}, 64'h0);
      ack();

      // STATUS clear and set in the same cycle reads 1
      cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 32'hFFFF_FFFF;
      fire(32'h20, 32'h300);
      cfg_we = 1'b0;
      expect_entry(32'h20, 32'h300);
      rd_check("status_clr_set", 2'd1, 32'h20);
      fire(32'h0, 32'h0);
      drain(1);
      ack();

      // DROP saturates at all-ones
      for (int unsigned i = 0; i < 268; i++) begin
         fire((i % 2 == 0) ? 32'h1 : 32'h2, 32'h2000 + i);
         if (i < 8) expect_entry((i % 2 == 0) ? 32'h1 : 32'h2, 32'h2000 + i);
      end
      fire(32'h0, 32'h0);
      rd_check("ctrl_drop_sat", 2'd3, 32'h1FF8);
      drain(8);
      cfg_write(2'd3, 32'h1);
      ack();

      // 5. ack coinciding with a new event keeps the IRQ pending
      check("irq_idle_pre", {63'h0, irq}, 64'h0);
      fire(32'h40, 32'h400);
      expect_entry(32'h40, 32'h400);
      irq_ack = 1'b1;
      fire(32'h80, 32'h404);
      irq_ack = 1'b0;
      expect_entry(32'h80, 32'h404);
      check("irq_ack_with_event", {63'h0, irq}, 64'h1);
      fire(32'h0, 32'h0);
      ack();
      check("irq_ack_alone", {63'h0, irq}, 64'h0);
      drain(2);

      // 6. halt
`ifdef OR1200_ASSERT_HALT_EN
      cfg_write(2'd2, 32'h0004_0000);
      rd_check("halt_mask_rb", 2'd2, 32'h0004_0000);
      fire(32'h0004_0000, 32'h500);
      expect_entry(32'h0004_0000, 32'h500);
      check("halt_set", {63'h0, halt_req}, 64'h1);
      check("halt_irq", {63'h0, irq}, 64'h1);
      step();
      check("halt_held", {63'h0, halt_req}, 64'h1);
      ack();
      check("halt_cleared", {63'h0, halt_req}, 64'h0);
      check("halt_irq_cleared", {63'h0, irq}, 64'h0);
`else
      cfg_write(2'd2, 32'h0004_0000);
      rd_check("halt_mask_absent", 2'd2, 32'h0);
      fire(32'h0004_0000, 32'h500);
      expect_entry(32'h0004_0000, 32'h500);
      check("halt_absent", {63'h0, halt_req}, 64'h0);
      check("halt_absent_irq", {63'h0, irq}, 64'h1);
      ack();
`endif
      fire(32'h0, 32'h0);
      drain(1);

      // reset mid-operation: held bit re-fires afterwards
      fire(32'h2, 32'h600);
      check("pre_reset_valid", {63'h0, ev_valid}, 64'h1);
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("reset_async_valid", {63'h0, ev_valid}, 64'h0);
      check("reset_async_irq", {63'h0, irq}, 64'h0);
      step();
      rst = 1'b0;
      ex_pc = 32'h604;
      step();
      expect_entry(32'h2, 32'h604);
      check("refire_after_reset", {63'h0, ev_valid}, 64'h1);
      fire(32'h0, 32'h0);
      drain(1);
      ack();

      check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
